// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch controller: reset/NOP defaults and the fetch FSM encoding.
package pipeline_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StHalt  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// IF-stage producer: owns the PC, selects the next PC, and feeds the IF/ID register with
// stall, redirect-squash and sticky-halt handling.
module pipeline_fetch_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [31:0]      Instr_Mem_Data,
    input  logic             LoadUse_Hazard,
    input  logic             Ext_Stall,
    input  logic             Branch_Taken,
    input  logic [31:0]      Branch_Target,
    input  logic             Jump,
    input  logic [31:0]      Jump_Target,
    input  logic             Halt,
    output logic [31:0]      PCF,
    output logic [31:0]      PCPlus4F,
    output logic [31:0]      InstructionF,
    output logic             Fetch_Enable,
    output logic             Halted,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         stall;
    logic         fetch_en;
    logic [31:0]  instr;
    logic         stall_inc;
    logic         flush_inc;

    assign stall = LoadUse_Hazard | Ext_Stall;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fetch_en  = 1'b1;
        instr     = NOP_WORD;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        unique case (state_q)
            StHalt: begin
                // Keep writing bubbles so the downstream pipe drains.
            end
            StRun, StStall: begin
                if (Halt) begin
                    state_d = StHalt;
                end else if (stall) begin
                    // Redirects are ignored; decode is frozen and re-presents them later.
                    state_d   = StStall;
                    fetch_en  = 1'b0;
                    stall_inc = 1'b1;
                end else if (Jump) begin
                    state_d   = StRun;
                    pc_d      = Jump_Target;
                    flush_inc = 1'b1;
                end else if (Branch_Taken) begin
                    state_d   = StRun;
                    pc_d      = Branch_Target;
                    flush_inc = 1'b1;
                end else begin
                    state_d = StRun;
                    pc_d    = pc_q + 32'd4;
                    instr   = Instr_Mem_Data;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (!Rst_n) begin
            fetch_en = 1'b0;
            instr    = NOP_WORD;
        end
    end

    assign PCF          = pc_q;
    assign PCPlus4F     = pc_q + 32'd4;
    assign InstructionF = instr;
    assign Fetch_Enable = fetch_en;
    assign Halted       = (state_q == StHalt);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (stall_inc),
        .count (Stall_Cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (flush_inc),
        .count (Flush_Count)
    );

endmodule

// File: doc/pipeline_fetch_ctrl.md
Name: pipeline_fetch_ctrl

Overview:
- Producer side of the IF/ID interface: owns the PC register, next-PC selection, and drives PCPlus4F, InstructionF and Fetch_Enable into the IF/ID pipeline register.
- Applies load-use / memory stalls, taken-branch and jump redirects with single-slot squash (NOP injection), and a sticky halt.
- Sits between instruction memory (combinational read) and the IF/ID register; hazard unit and decode stage feed its control inputs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word injected on squash/halt/reset.
- CNT_W, 16, width of stall/flush performance counters.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Instr_Mem_Data  in  32  word read from instruction memory at PCF.
- LoadUse_Hazard  in  1  hazard unit: hold IF and ID this cycle.
- Ext_Stall  in  1  memory not ready: hold IF and ID this cycle.
- Branch_Taken  in  1  branch resolved taken in ID.
- Branch_Target  in  32  branch destination.
- Jump  in  1  jump decoded in ID.
- Jump_Target  in  32  jump destination.
- Halt  in  1  halt request from decode (syscall/illegal op).
- PCF  out  32  current fetch address to instruction memory.
- PCPlus4F  out  32  PCF + 4, to IF/ID.
- InstructionF  out  32  Instr_Mem_Data or NOP_WORD, to IF/ID.
- Fetch_Enable  out  1  IF/ID write enable.
- Halted  out  1  high while in HALT.
- Stall_Cycles  out  CNT_W  cycles spent stalled.
- Flush_Count  out  CNT_W  number of redirects taken.

Behaviour:
- Reset (Rst_n=0, async): PCF=RESET_PC, state=RUN, counters=0; while asserted Fetch_Enable=0, InstructionF=NOP_WORD, Halted=0.
- PCPlus4F = PCF + 4, combinational, modulo 2^32 (PCF=32'hFFFF_FFFC gives 0).
- FSM states RUN, STALL, HALT; state and PCF are the only registers besides the counters.
- Priority per cycle in RUN/STALL: Halt > stall (LoadUse_Hazard | Ext_Stall) > Jump > Branch_Taken > sequential.
- Halt: next state HALT; PCF holds; Fetch_Enable=1, InstructionF=NOP_WORD (drains pipe with bubbles). HALT is sticky until reset; Halted=1 from the cycle after entry.
- Stall: PCF holds, Fetch_Enable=0, state=STALL, Stall_Cycles+1 (saturating at all-ones). Redirect inputs are ignored; decode is frozen and re-presents them once the stall clears.
- Jump (no stall): PCF<=Jump_Target; Fetch_Enable=1; InstructionF=NOP_WORD for that cycle (squashes the wrong-path fetch); Flush_Count+1 (saturating).
- Branch_Taken (no stall, no jump): same as jump using Branch_Target.
- Jump and Branch_Taken both high: Jump wins, one flush counted.
- Sequential: PCF<=PCF+4, Fetch_Enable=1, InstructionF=Instr_Mem_Data, state=RUN.
- STALL to RUN transition happens on the first cycle with no stall; that cycle behaves as RUN (redirect or sequential).
- Targets are used unmodified; no alignment check.
- Reset mid-stall or mid-halt returns to RESET_PC and RUN immediately.

Decomposition:
- Shared package (pipeline_pkg): RESET_PC, NOP_WORD, FSM state encoding (2-bit).
- Sub-module sat_counter (CNT_W, inc, async clear) instantiated twice for Stall_Cycles and Flush_Count.

Test Plan:
- Reset release, no stimulus, Instr_Mem_Data=32'h2008_0005: PCF goes 0,4,8; Fetch_Enable=1; InstructionF=32'h2008_0005; PCPlus4F=PCF+4.
- LoadUse_Hazard high for 2 cycles at PCF=8: PCF stays 8, Fetch_Enable=0 for both cycles, Stall_Cycles=2, then PCF=C.
- Branch_Taken=1, Branch_Target=32'h40 at PCF=10: next PCF=40, InstructionF=0 that cycle, Flush_Count=1.
- Jump=1 (target 32'h100) and Branch_Taken=1 (target 32'h40) with Ext_Stall=1: PCF holds, no flush. Next cycle without stall: PCF=100, Flush_Count=1.
- Halt at PCF=20: InstructionF=0, PCF frozen at 20 for 10 cycles, Halted=1. Then Rst_n low mid-halt: PCF=0, Halted=0 asynchronously.
- PCF forced to FFFF_FFFC via Jump: PCPlus4F=0; the next sequential PCF is 0.
